lvds_rx_word_align: RTL and testbench
=====================================

Name: lvds_rx_word_align

Overview:
Parametrised per-lane word aligner for the LVDS 7:1 camera receive path, placed after the DDR capture/gearbox that delivers raw RATIO-bit words per lane on the parallel clock. Each lane independently finds the bit offset at which the training pattern appears, holds it, and optionally monitors the link for loss of lock.
Adds over the fixed 4-lane receiver:
- configurable lane count and deserialisation ratio
- lock qualification by consecutive matches
- lock loss on repeated errors
- per-lane offset and search-fail reporting
- a retrain request

Parameters:
NUM_LANES, 4, number of data lanes.
RATIO, 7, bits per parallel word (supported range 4..10).
MATCH_COUNT, 16, consecutive pattern matches required to declare lock (>=1).
ERR_LIMIT, 4, consecutive mismatches while locked and train_en=1 that drop lock (>=1).
OFS_W, clog2(RATIO), derived localparam; not to be overridden.

Ports:
parallel_clk  in  1  sole clock.
reset  in  1  synchronous, active-high.
raw_valid  in  1  raw_data beat qualifier.
raw_data  in  NUM_LANES*RATIO  lane i = [i*RATIO +: RATIO], bit 0 earliest received.
training_pattern  in  RATIO  expected aligned word; quasi-static.
train_en  in  1  level: 1 = training traffic present (enables search and lock monitoring).
retrain  in  1  single-cycle request to restart alignment on all lanes.
rdata  out  NUM_LANES*RATIO  aligned words, same lane packing as raw_data.
rdata_valid  out  1  aligned beat valid.
lane_aligned  out  NUM_LANES  per-lane LOCKED indicator.
all_aligned  out  1  AND of lane_aligned.
lane_offset  out  NUM_LANES*OFS_W  current bit offset per lane.
search_fail  out  NUM_LANES  sticky: a full offset sweep completed without a match.

Behaviour:
Reset:
- All outputs 0.
- Per-lane prev register 0, offset 0, match and error counters 0, state IDLE.

Datapath, per lane:
- window = {raw_data_lane, prev} (2*RATIO bits, prev in the low half).
- aligned = window[offset +: RATIO].
- On raw_valid:
  - prev <= raw_data_lane
  - rdata lane <= aligned
- rdata_valid <= raw_valid & all lanes LOCKED (evaluated before this cycle's state update).
- Latency: one cycle from raw_valid to rdata/rdata_valid.
- rdata holds its value when raw_valid=0.

Per-lane FSM. It advances only on raw_valid=1, except retrain. match = (aligned == training_pattern).
- IDLE: train_en=1 -> SEARCH.
- SEARCH:
  - match -> VERIFY, match_cnt=1; if MATCH_COUNT==1, go straight to LOCKED.
  - mismatch -> offset = (offset==RATIO-1) ? 0 : offset+1. On the wrap, set search_fail.
  - train_en=0 -> IDLE, offset kept.
- VERIFY:
  - match -> match_cnt+1; reaching MATCH_COUNT -> LOCKED, clear search_fail.
  - mismatch -> SEARCH, offset advanced by 1 (with wrap), match_cnt=0.
- LOCKED:
  - lane_aligned=1.
  - train_en=1: mismatch -> err_cnt+1; match -> err_cnt=0; err_cnt reaching ERR_LIMIT -> SEARCH, offset kept, err_cnt=0.
  - train_en=0: no monitoring, err_cnt=0, lock held indefinitely.

Priority and boundary cases:
- retrain=1 (any state, regardless of raw_valid) -> SEARCH if train_en=1 else IDLE; offset 0, counters 0, search_fail 0.
- retrain overrides a same-cycle state transition; reset overrides retrain.
- search_fail stays set while searching continues; it clears only on lock, retrain or reset.
- all_aligned and lane_aligned are registered state decodes: rising in the cycle after the qualifying beat, falling in the cycle after lock loss or retrain.
- Counters saturate: match_cnt at MATCH_COUNT, err_cnt at ERR_LIMIT.
- Lanes never interact except through all_aligned/rdata_valid.

Decomposition:
- Package lvds_rx_pkg holds: the lane state enum (IDLE, SEARCH, VERIFY, LOCKED), the clog2-based OFS_W helper, and counter width helpers for MATCH_COUNT/ERR_LIMIT.
- Sub-module lvds_rx_lane_align contains one lane's window, barrel select, FSM and counters.
- The top generates NUM_LANES instances and adds the all_aligned AND and the rdata_valid register.

Test Plan:
1. NUM_LANES=4, RATIO=7, pattern 7'b1100011, train_en=1, continuous raw_valid. Lanes carry the pattern starting at bit 0/2/5/6 of each raw word -> lane_offset = 0/2/5/6; all_aligned=1 within RATIO+MATCH_COUNT+2 beats; rdata = 7'b1100011 on every lane.
2. After lock, corrupt lane 1 for 3 beats, then 4 beats, with ERR_LIMIT=4 -> 3 beats: lane 1 stays locked. 4 beats: lane_aligned[1] falls the cycle after the 4th error, then relocks at offset 2; the other lanes are unaffected.
3. Lane 3 sends constant 7'b0000000 -> search_fail[3] sets after 7 beats and remains 1; all_aligned=0; rdata_valid never asserts.
4. Locked, then train_en=0 and random data -> lock held, rdata_valid=1 each beat with one-cycle latency, offsets unchanged.
5. retrain pulse while locked (same cycle as a mismatch) -> all lanes SEARCH at offset 0; search_fail=0; relock to the same offsets.
6. raw_valid toggling 1/0 during the search, plus reset asserted mid-VERIFY -> the FSM advances only on valid beats; on reset, all outputs 0 next cycle and state IDLE.

Source files
------------

// File: rtl/lvds_rx_pkg.sv
// Shared types and width helpers for the LVDS receive word aligner.
package lvds_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } lane_state_t;

  function automatic int ofs_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int match_cnt_width(input int match_count);
    return $clog2(match_count + 1);
  endfunction

  function automatic int err_cnt_width(input int err_limit);
    return $clog2(err_limit + 1);
  endfunction

endpackage

// File: rtl/lvds_rx_lane_align.sv
// One lane: two-word window, barrel select at the current offset, and the
// search / verify / lock state machine with its counters.
module lvds_rx_lane_align
  import lvds_rx_pkg::*;
#(
  parameter int RATIO       = 7,
  parameter int MATCH_COUNT = 16,
  parameter int ERR_LIMIT   = 4,
  localparam int OFS_W      = ofs_width(RATIO)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_valid,
  input  logic [RATIO-1:0] raw_lane,
  input  logic [RATIO-1:0] training_pattern,
  input  logic             train_en,
  input  logic             retrain,
  output logic [RATIO-1:0] rdata_lane,
  output logic             locked,
  output logic [OFS_W-1:0] offset,
  output logic             search_fail
);

  localparam int MC_W = match_cnt_width(MATCH_COUNT);
  localparam int EC_W = err_cnt_width(ERR_LIMIT);
  localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(RATIO - 1);
  localparam logic [MC_W-1:0]  MC_MAX   = MC_W'(MATCH_COUNT);
  localparam logic [EC_W-1:0]  EC_MAX   = EC_W'(ERR_LIMIT);

  logic [RATIO-1:0]   prev_r;
  logic [2*RATIO-1:0] window_s;
  logic [RATIO-1:0]   aligned_s;
  logic               match_s;
  logic               ofs_wrap_s;
  logic [OFS_W-1:0]   ofs_next_s;
  lane_state_t        state_r;
  logic [MC_W-1:0]    match_cnt_r;
  logic [EC_W-1:0]    err_cnt_r;

  // Barrel select of the aligned word and next search offset.
  always_comb begin
    window_s   = {raw_lane, prev_r};
    aligned_s  = RATIO'(window_s >> offset);
    match_s    = (aligned_s == training_pattern);
    ofs_wrap_s = (offset == OFS_LAST);
    ofs_next_s = ofs_wrap_s ? {OFS_W{1'b0}} : offset + OFS_W'(1);
  end

  // Previous-word history and aligned output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r     <= '0;
      rdata_lane <= '0;
    end else if (raw_valid) begin
      prev_r     <= raw_lane;
      rdata_lane <= aligned_s;
    end
  end

  // Alignment state machine; retrain beats any beat-driven transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      offset      <= '0;
      match_cnt_r <= '0;
      err_cnt_r   <= '0;
      search_fail <= 1'b0;
      locked      <= 1'b0;
    end else if (retrain) begin
      state_r     <= train_en ? SEARCH : IDLE;
      offset      <= '0;
      match_cnt_r <= '0;
      err_cnt_r   <= '0;
      search_fail <= 1'b0;
      locked      <= 1'b0;
    end else if (raw_valid) begin
      case (state_r)
        IDLE: begin
          if (train_en) state_r <= SEARCH;
        end
        SEARCH: begin
          if (!train_en) begin
            state_r <= IDLE;
          end else if (match_s) begin
            match_cnt_r <= MC_W'(1);
            if (MATCH_COUNT == 1) begin
              state_r     <= LOCKED;
              locked      <= 1'b1;
              search_fail <= 1'b0;
              err_cnt_r   <= '0;
            end else begin
              state_r <= VERIFY;
            end
          end else begin
            offset <= ofs_next_s;
            if (ofs_wrap_s) search_fail <= 1'b1;
          end
        end
        VERIFY: begin
          if (match_s) begin
            if (match_cnt_r >= MC_MAX - MC_W'(1)) begin
              state_r     <= LOCKED;
              locked      <= 1'b1;
              search_fail <= 1'b0;
              err_cnt_r   <= '0;
              match_cnt_r <= MC_MAX;
            end else begin
              match_cnt_r <= match_cnt_r + MC_W'(1);
            end
          end else begin
            state_r     <= SEARCH;
            offset      <= ofs_next_s;
            match_cnt_r <= '0;
          end
        end
        LOCKED: begin
          // Without training traffic the lock is held unconditionally.
          if (!train_en) begin
            err_cnt_r <= '0;
          end else if (match_s) begin
            err_cnt_r <= '0;
          end else if (err_cnt_r >= EC_MAX - EC_W'(1)) begin
            state_r     <= SEARCH;
            locked      <= 1'b0;
            err_cnt_r   <= '0;
            match_cnt_r <= '0;
          end else begin
            err_cnt_r <= err_cnt_r + EC_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lvds_rx_word_align.sv
// Multi-lane word aligner: independent per-lane alignment, aligned output
// qualified only while every lane is locked.
module lvds_rx_word_align
  import lvds_rx_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int RATIO       = 7,
  parameter int MATCH_COUNT = 16,
  parameter int ERR_LIMIT   = 4,
  localparam int OFS_W      = ofs_width(RATIO)
) (
  input  logic                       parallel_clk,
  input  logic                       reset,
  input  logic                       raw_valid,
  input  logic [NUM_LANES*RATIO-1:0] raw_data,
  input  logic [RATIO-1:0]           training_pattern,
  input  logic                       train_en,
  input  logic                       retrain,
  output logic [NUM_LANES*RATIO-1:0] rdata,
  output logic                       rdata_valid,
  output logic [NUM_LANES-1:0]       lane_aligned,
  output logic                       all_aligned,
  output logic [NUM_LANES*OFS_W-1:0] lane_offset,
  output logic [NUM_LANES-1:0]       search_fail
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lvds_rx_lane_align #(
      .RATIO       (RATIO),
      .MATCH_COUNT (MATCH_COUNT),
      .ERR_LIMIT   (ERR_LIMIT)
    ) u_lane (
      .clk              (parallel_clk),
      .reset            (reset),
      .raw_valid        (raw_valid),
      .raw_lane         (raw_data[i*RATIO +: RATIO]),
      .training_pattern (training_pattern),
      .train_en         (train_en),
      .retrain          (retrain),
      .rdata_lane       (rdata[i*RATIO +: RATIO]),
      .locked           (lane_aligned[i]),
      .offset           (lane_offset[i*OFS_W +: OFS_W]),
      .search_fail      (search_fail[i])
    );
  end

  assign all_aligned = &lane_aligned;

  // Output qualifier uses the lock state seen before this beat's update.
  always_ff @(posedge parallel_clk) begin
    if (reset) begin
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= raw_valid & all_aligned;
    end
  end

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// Randomised scoreboard bench for lvds_rx_word_align with a behavioural
// per-lane alignment model.
module tb_lvds_rx_word_align;

  localparam int NL = 4;
  localparam int R  = 7;
  localparam int MC = 16;
  localparam int EL = 4;
  localparam int OW = 3;
  localparam logic [R-1:0] PAT = 7'b1100011;

  logic              parallel_clk = 1'b0;
  logic              reset, raw_valid, train_en, retrain;
  logic [NL*R-1:0]   raw_data, rdata;
  logic [R-1:0]      training_pattern;
  logic              rdata_valid, all_aligned;
  logic [NL-1:0]     lane_aligned, search_fail;
  logic [NL*OW-1:0]  lane_offset;

  lvds_rx_word_align #(.NUM_LANES(NL), .RATIO(R), .MATCH_COUNT(MC), .ERR_LIMIT(EL)) dut (
    .parallel_clk     (parallel_clk),
    .reset            (reset),
    .raw_valid        (raw_valid),
    .raw_data         (raw_data),
    .training_pattern (training_pattern),
    .train_en         (train_en),
    .retrain          (retrain),
    .rdata            (rdata),
    .rdata_valid      (rdata_valid),
    .lane_aligned     (lane_aligned),
    .all_aligned      (all_aligned),
    .lane_offset      (lane_offset),
    .search_fail      (search_fail)
  );

  always #5 parallel_clk = ~parallel_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [NL*R-1:0] exp_q[$];

  // Stimulus: per-lane mode (0 pattern, 1 pattern with low bits flipped, 2 zeros, 3 random)
  int mode[NL];
  int shift[NL];

  // Model: engaged = training started; run = consecutive matches (MC means locked)
  bit m_eng[NL];
  int m_run[NL];
  int m_errs[NL];
  int m_ofs[NL];
  bit m_fail[NL];
  int m_prev[NL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [R-1:0] rot_pat(input int k);
    logic [R-1:0] p;
    logic [R-1:0] w;
    p = PAT;
    w = '0;
    for (int j = 0; j < R; j++) w[(k + j) % R] = p[j];
    return w;
  endfunction

  function automatic logic [R-1:0] gen_lane(input int i);
    case (mode[i])
      0: return rot_pat(shift[i]);
      1: return rot_pat(shift[i]) ^ 7'b0000011;
      2: return 7'b0000000;
      default: return R'($urandom);
    endcase
  endfunction

  task automatic step(input logic v, input logic te, input logic rt, input logic rst);
    logic [NL*R-1:0] d;
    logic [NL*R-1:0] exp_word;
    logic [NL-1:0]   exp_al, exp_fail;
    logic [NL*OW-1:0] exp_ofs;
    bit all_lock, exp_rv, match;
    int cur, win, al;
    for (int i = 0; i < NL; i++) d[i*R +: R] = v ? gen_lane(i) : R'($urandom);
    raw_valid = v; raw_data = d; train_en = te; retrain = rt; reset = rst;

    all_lock = 1'b1;
    for (int i = 0; i < NL; i++) if (m_run[i] != MC) all_lock = 1'b0;
    exp_rv = !rst && v && all_lock;

    for (int i = 0; i < NL; i++) begin
      cur = int'(d[i*R +: R]);
      win = cur * (1 << R) + m_prev[i];
      al  = (win / (1 << m_ofs[i])) % (1 << R);
      exp_word[i*R +: R] = R'(al);
      match = (al == int'(PAT));
      if (rst) begin
        m_eng[i] = 0; m_run[i] = 0; m_errs[i] = 0; m_ofs[i] = 0; m_fail[i] = 0; m_prev[i] = 0;
      end else begin
        if (v) m_prev[i] = cur;
        if (rt) begin
          m_eng[i] = te; m_run[i] = 0; m_errs[i] = 0; m_ofs[i] = 0; m_fail[i] = 0;
        end else if (v) begin
          if (!m_eng[i]) begin
            if (te) m_eng[i] = 1;
          end else if (m_run[i] == 0) begin
            if (!te) m_eng[i] = 0;
            else if (match) begin
              m_run[i] = 1;
              if (m_run[i] == MC) begin m_fail[i] = 0; m_errs[i] = 0; end
            end else if (m_ofs[i] == R - 1) begin
              m_ofs[i] = 0; m_fail[i] = 1;
            end else m_ofs[i]++;
          end else if (m_run[i] < MC) begin
            if (match) begin
              m_run[i]++;
              if (m_run[i] == MC) begin m_fail[i] = 0; m_errs[i] = 0; end
            end else begin
              m_run[i] = 0; m_ofs[i] = (m_ofs[i] + 1) % R;
            end
          end else begin
            if (!te || match) m_errs[i] = 0;
            else begin
              m_errs[i]++;
              if (m_errs[i] == EL) begin m_errs[i] = 0; m_run[i] = 0; end
            end
          end
        end
      end
    end
    if (exp_rv) exp_q.push_back(exp_word);

    for (int i = 0; i < NL; i++) begin
      exp_al[i]   = (m_run[i] == MC);
      exp_fail[i] = m_fail[i];
      exp_ofs[i*OW +: OW] = OW'(m_ofs[i]);
    end

    @(posedge parallel_clk);
    #1;
    check("rdata_valid", rdata_valid, exp_rv);
    check("lane_aligned", lane_aligned, exp_al);
    check("all_aligned", all_aligned, &exp_al);
    check("lane_offset", lane_offset, exp_ofs);
    check("search_fail", search_fail, exp_fail);
  endtask

  // Monitor: every presented beat must match the oldest predicted word.
  always @(negedge parallel_clk) begin
    if (rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rdata: unexpected beat 0x%0h, none predicted", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    training_pattern = PAT;
    raw_valid = 1'b0; raw_data = '0; train_en = 1'b0; retrain = 1'b0; reset = 1'b1;
    shift = '{0, 2, 5, 6};
    mode  = '{0, 0, 0, 0};

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_rdata", rdata, '0);

    // Initial alignment at offsets 0/2/5/6 within RATIO+MATCH_COUNT+2 beats
    for (int n = 0; n < R + MC + 2; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("lock_in_time", all_aligned, 1'b1);
    check("lock_offsets", lane_offset, {3'd6, 3'd5, 3'd2, 3'd0});
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rdata_pattern", rdata, {NL{PAT}});

    // Error bursts on lane 1: 3 tolerated, 4 drops lock
    mode[1] = 1;
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    mode[1] = 0;
    check("lane1_hold", lane_aligned, 4'b1111);
    for (int n = 0; n < 10; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    mode[1] = 1;
    for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    mode[1] = 0;
    check("lane1_drop", lane_aligned, 4'b1101);
    for (int n = 0; n < 20; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("lane1_relock", lane_offset, {3'd6, 3'd5, 3'd2, 3'd0});

    // Lane 3 dead: full sweep fails, sticky
    mode[3] = 2;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("lane3_fail", search_fail[3], 1'b1);
    for (int n = 0; n < 20; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("lane3_fail_sticky", search_fail[3], 1'b1);
    check("lane3_not_all", all_aligned, 1'b0);

    // Recover, then random traffic with training off
    mode[3] = 0;
    for (int n = 0; n < 30; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("recover_fail_clear", search_fail, 4'b0000);
    mode = '{3, 3, 3, 3};
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_offsets", lane_offset, {3'd6, 3'd5, 3'd2, 3'd0});
    check("hold_lock", all_aligned, 1'b1);

    // Retrain together with a mismatch beat
    mode = '{0, 0, 0, 0};
    step(1'b1, 1'b1, 1'b0, 1'b0);
    mode[2] = 1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    mode[2] = 0;
    check("retrain_offsets", lane_offset, '0);
    check("retrain_unlock", lane_aligned, 4'b0000);
    for (int n = 0; n < 30; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("retrain_relock", lane_offset, {3'd6, 3'd5, 3'd2, 3'd0});

    // Gapped valid during search, reset while lane 0 verifies
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 11; n++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("midreset_rdata", rdata, '0);
    check("midreset_lock", lane_aligned, 4'b0000);
    for (int n = 0; n < 6; n++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);

    // Random soak
    for (int i = 0; i < NL; i++) shift[i] = $urandom_range(0, R - 1);
    train_en = 1'b1;
    begin
      logic te_v;
      te_v = 1'b1;
      for (int n = 0; n < 500; n++) begin
        for (int i = 0; i < NL; i++) begin
          case ($urandom_range(0, 29))
            0: mode[i] = 1;
            1: mode[i] = 3;
            default: mode[i] = 0;
          endcase
        end
        if ($urandom_range(0, 59) == 0) te_v = ~te_v;
        step(1'($urandom_range(0, 3) != 0), te_v, 1'($urandom_range(0, 99) == 0),
             1'($urandom_range(0, 299) == 0));
      end
    end

    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
